// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Time-shares one external 8-bit ALU between two requesters. A request is
// accepted through a valid/ready handshake, its operands and select are
// registered onto the ALU, the result is sampled ALU_WAIT cycles later and
// returned with the requester ID through a second valid/ready handshake.
// Only one operation is ever in flight.
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN  defined   -> requester 0 always wins a contested grant
//                          undefined -> round-robin on the last-granted ID
module alu_share_arbiter #(
   parameter int ALU_WAIT = 1            // legal range 1..15
) (
   input  logic       CLK,
   input  logic       RESET,             // synchronous, active low
   input  logic       REQ0_VALID,
   output logic       REQ0_READY,
   input  logic [2:0] REQ0_OP,
   input  logic [7:0] REQ0_A,
   input  logic [7:0] REQ0_B,
   input  logic       REQ1_VALID,
   output logic       REQ1_READY,
   input  logic [2:0] REQ1_OP,
   input  logic [7:0] REQ1_A,
   input  logic [7:0] REQ1_B,
   output logic [7:0] ALU_DATA1,
   output logic [7:0] ALU_DATA2,
   output logic [2:0] ALU_SELECT,
   input  logic [7:0] ALU_RESULT,
   output logic       RSP_VALID,
   output logic       RSP_ID,
   output logic [7:0] RSP_RESULT,
   input  logic       RSP_READY
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [3:0] WAIT_LOAD = 4'(ALU_WAIT);

   logic [1:0] state;
   logic [3:0] cnt;
   logic       cur_id;
   logic       gnt_valid;
   logic       gnt_id;
   logic       idle;
   logic       accept;
   logic       cnt_done;
   logic [2:0] gnt_op;
   logic [7:0] gnt_a;
   logic [7:0] gnt_b;

`ifndef ALU_ARB_FIXED_PRIO_EN
   logic       ptr;                      // last-granted requester ID
`endif

   // Grant selection from the two valids (and the round-robin pointer).
   always_comb begin
      gnt_valid = REQ0_VALID | REQ1_VALID;
`ifdef ALU_ARB_FIXED_PRIO_EN
      gnt_id    = ~REQ0_VALID;
`else
      if (REQ0_VALID && REQ1_VALID)
         gnt_id = ~ptr;
      else
         gnt_id = ~REQ0_VALID;
`endif
   end

   // Handshake qualifiers: readies only in IDLE and never while reset is held.
   always_comb begin
      idle       = (state == ST_IDLE) && RESET;
      accept     = idle && gnt_valid;
      REQ0_READY = accept && !gnt_id;
      REQ1_READY = accept &&  gnt_id;
   end

   // Payload mux for the granted requester.
   always_comb begin
      gnt_op = gnt_id ? REQ1_OP : REQ0_OP;
      gnt_a  = gnt_id ? REQ1_A  : REQ0_A;
      gnt_b  = gnt_id ? REQ1_B  : REQ0_B;
   end

   // Last wait cycle; <= 1 also guards against a misconfigured ALU_WAIT of 0.
   always_comb begin
      cnt_done = (cnt <= 4'd1);
   end

   // Sequencer state and wait counter.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state  <= ST_IDLE;
         cnt    <= 4'd0;
         cur_id <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state  <= ST_EXEC;
                  cnt    <= WAIT_LOAD;
                  cur_id <= gnt_id;
               end
            end
            ST_EXEC: begin
               cnt <= (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
               if (cnt_done)
                  state <= ST_RESP;
            end
            ST_RESP: begin
               if (RSP_READY)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // ALU operand/select registers; they change only on acceptance.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         ALU_DATA1  <= 8'd0;
         ALU_DATA2  <= 8'd0;
         ALU_SELECT <= 3'd0;
      end else if (accept) begin
         ALU_DATA1  <= gnt_a;
         ALU_DATA2  <= gnt_b;
         ALU_SELECT <= gnt_op;
      end
   end

   // Response capture and hold until the consumer takes it.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         RSP_VALID  <= 1'b0;
         RSP_ID     <= 1'b0;
         RSP_RESULT <= 8'd0;
      end else if ((state == ST_EXEC) && cnt_done) begin
         RSP_VALID  <= 1'b1;
         RSP_ID     <= cur_id;
         RSP_RESULT <= ALU_RESULT;
      end else if ((state == ST_RESP) && RSP_READY) begin
         RSP_VALID  <= 1'b0;
      end
   end

`ifndef ALU_ARB_FIXED_PRIO_EN
   // Round-robin pointer; reset to 1 so requester 0 wins the first contest.
   always_ff @(posedge CLK) begin
      if (!RESET)
         ptr <= 1'b1;
      else if (accept)
         ptr <= gnt_id;
   end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: a behavioural ALU drives
// ALU_RESULT, a table of single requests and hand-written multi-cycle
// sequences are checked against constants, then randomized traffic is
// checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_alu_share_arbiter;

   localparam int W = 4;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
   logic       REQ0_READY, REQ1_READY;
   logic [2:0] REQ0_OP = '0, REQ1_OP = '0;
   logic [7:0] REQ0_A = '0, REQ0_B = '0, REQ1_A = '0, REQ1_B = '0;
   logic [7:0] ALU_DATA1, ALU_DATA2, ALU_RESULT;
   logic [2:0] ALU_SELECT;
   logic       RSP_VALID, RSP_ID, RSP_READY = 1'b1;
   logic [7:0] RSP_RESULT;

   int checks = 0;
   int errors = 0;

   alu_share_arbiter #(.ALU_WAIT(W)) dut (
      .CLK(CLK), .RESET(RESET),
      .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_OP(REQ0_OP),
      .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
      .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_OP(REQ1_OP),
      .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
      .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT),
      .ALU_RESULT(ALU_RESULT),
      .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_RESULT(RSP_RESULT),
      .RSP_READY(RSP_READY)
   );

   always #5 CLK = ~CLK;

   // Behavioural ALU; reserved selects return XOR so they are distinguishable.
   function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
      case (s)
         3'b000:  return a;
         3'b001:  return a + b;
         3'b010:  return a & b;
         3'b011:  return a | b;
         default: return a ^ b;
      endcase
   endfunction

   always_comb ALU_RESULT = alu_f(ALU_SELECT, ALU_DATA1, ALU_DATA2);

   // Reference arbitration rule: -1 means no grant.
   function automatic int pick(input logic v0, input logic v1, input int last);
      if (!v0 && !v1) return -1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      return v0 ? 0 : 1;
`else
      if (v0 && v1) return (last == 0) ? 1 : 0;
      return v0 ? 0 : 1;
`endif
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_in();
      REQ0_VALID = 1'b0;
      REQ1_VALID = 1'b0;
   endtask

   task automatic set_req(input logic id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      if (!id) begin
         REQ0_VALID = 1'b1; REQ0_OP = op; REQ0_A = a; REQ0_B = b;
      end else begin
         REQ1_VALID = 1'b1; REQ1_OP = op; REQ1_A = a; REQ1_B = b;
      end
   endtask

   // Advance until RSP_VALID, counting edges; bounded.
   task automatic wait_rsp(output int n);
      n = 0;
      while (!RSP_VALID && n < 40) begin
         step();
         n++;
      end
   endtask

   typedef struct {
      logic       id;
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int n;
      int seen;
      int expid;
      // reference model state for the random phase
      int mode, age, last, g;
      logic [7:0] m_d1, m_d2, m_res;
      logic [2:0] m_sel;
      logic m_id, keep0, keep1;

      tbl[0] = '{1'b0, 3'b011, 8'h07, 8'h04, 8'h07};
      tbl[1] = '{1'b1, 3'b001, 8'h05, 8'h03, 8'h08};
      tbl[2] = '{1'b0, 3'b010, 8'h0C, 8'h0A, 8'h08};
      tbl[3] = '{1'b1, 3'b000, 8'hA5, 8'h00, 8'hA5};
      tbl[4] = '{1'b0, 3'b001, 8'hFF, 8'h02, 8'h01};
      tbl[5] = '{1'b1, 3'b011, 8'hF0, 8'h0F, 8'hFF};
      tbl[6] = '{1'b0, 3'b101, 8'h3C, 8'h0F, 8'h33};
      tbl[7] = '{1'b0, 3'b000, 8'hA5, 8'h11, 8'hA5};

      // ---- reset state, with both valids asserted during reset
      RESET = 1'b0;
      set_req(1'b0, 3'b001, 8'h11, 8'h22);
      set_req(1'b1, 3'b001, 8'h33, 8'h44);
      step(); step();
      chk("rst ready0", REQ0_READY, 0);
      chk("rst ready1", REQ1_READY, 0);
      chk("rst data1", ALU_DATA1, 0);
      chk("rst data2", ALU_DATA2, 0);
      chk("rst select", ALU_SELECT, 0);
      chk("rst rsp_valid", RSP_VALID, 0);
      chk("rst rsp_id", RSP_ID, 0);
      chk("rst rsp_result", RSP_RESULT, 0);
      idle_in();
      RESET = 1'b1;
      step();

      // ---- contention: both held valid, grants alternate from requester 0
      RSP_READY = 1'b1;
      set_req(1'b0, 3'b001, 8'h05, 8'h03);
      set_req(1'b1, 3'b010, 8'h0C, 8'h0A);
      for (int k = 0; k < 4; k++) begin
         #1;
         n = 0;
         while (!(REQ0_READY || REQ1_READY) && n < 20) begin step(); n++; end
`ifdef ALU_ARB_FIXED_PRIO_EN
         expid = 0;
`else
         expid = k % 2;
`endif
         chk("contend grant valid", REQ0_READY | REQ1_READY, 1);
         chk("contend grant id", REQ1_READY, expid);
         step();
         wait_rsp(n);
         chk("contend latency", n, W);
         chk("contend rsp_id", RSP_ID, expid);
         chk("contend rsp_result", RSP_RESULT, 8'h08);
         step();
      end
      idle_in();
      step();

      // ---- table of single requests
      for (int i = 0; i < 8; i++) begin
         set_req(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b);
         #1;
         chk("single ready own", tbl[i].id ? REQ1_READY : REQ0_READY, 1);
         chk("single ready other", tbl[i].id ? REQ0_READY : REQ1_READY, 0);
         step();
         idle_in();
         chk("single select", ALU_SELECT, tbl[i].op);
         chk("single data1", ALU_DATA1, tbl[i].a);
         chk("single data2", ALU_DATA2, tbl[i].b);
         wait_rsp(n);
         chk("single latency", n, W);
         chk("single rsp_result", RSP_RESULT, tbl[i].exp);
         chk("single rsp_id", RSP_ID, tbl[i].id);
         step();
         chk("single rsp cleared", RSP_VALID, 0);
      end

      // ---- response backpressure
      RSP_READY = 1'b0;
      set_req(1'b1, 3'b000, 8'h3C, 8'h00);
      step();
      idle_in();
      set_req(1'b0, 3'b000, 8'h99, 8'h00);
      wait_rsp(n);
      chk("bp latency", n, W);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("bp rsp_valid", RSP_VALID, 1);
         chk("bp rsp_result", RSP_RESULT, 8'h3C);
         chk("bp rsp_id", RSP_ID, 1);
         chk("bp ready0", REQ0_READY, 0);
         chk("bp ready1", REQ1_READY, 0);
      end
      RSP_READY = 1'b1;
      step();
      chk("bp released", RSP_VALID, 0);
      chk("bp no same-cycle accept", ALU_DATA1, 8'h3C);
      chk("bp idle ready0", REQ0_READY, 1);
      idle_in();
      step();

      // ---- withdrawn request: REQ1 pulses once during EXEC
      set_req(1'b0, 3'b000, 8'h5A, 8'h00);
      step();
      idle_in();
      step();
      set_req(1'b1, 3'b011, 8'h01, 8'h02);
      #1;
      chk("withdraw ready1 in exec", REQ1_READY, 0);
      step();
      idle_in();
      wait_rsp(n);
      chk("withdraw rsp_valid", RSP_VALID, 1);
      chk("withdraw rsp_id", RSP_ID, 0);
      chk("withdraw rsp_result", RSP_RESULT, 8'h5A);
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (RSP_VALID || REQ1_READY) seen++;
      end
      chk("withdraw no residue", seen, 0);

      // ---- reset in the middle of EXEC (pointer would otherwise favour REQ1)
      set_req(1'b0, 3'b001, 8'h10, 8'h20);
      step();
      idle_in();
      step();
      RESET = 1'b0;
      set_req(1'b0, 3'b001, 8'h10, 8'h20);
      set_req(1'b1, 3'b010, 8'h30, 8'h40);
      step();
      chk("midrst data1", ALU_DATA1, 0);
      chk("midrst data2", ALU_DATA2, 0);
      chk("midrst select", ALU_SELECT, 0);
      chk("midrst rsp_valid", RSP_VALID, 0);
      chk("midrst rsp_id", RSP_ID, 0);
      chk("midrst rsp_result", RSP_RESULT, 0);
      chk("midrst ready0", REQ0_READY, 0);
      chk("midrst ready1", REQ1_READY, 0);
      idle_in();
      RESET = 1'b1;
      seen = 0;
      for (int k = 0; k < W + 3; k++) begin
         step();
         if (RSP_VALID) seen++;
      end
      chk("midrst no response", seen, 0);
      set_req(1'b0, 3'b001, 8'h10, 8'h20);
      set_req(1'b1, 3'b010, 8'h30, 8'h40);
      #1;
      chk("midrst contest ready0", REQ0_READY, 1);
      chk("midrst contest ready1", REQ1_READY, 0);
      idle_in();
      step();

      // ---- randomized traffic against the reference model
      // DUT is idle, pointer=1, ALU regs and response regs at reset values.
      mode = 0; age = 0; last = 1;
      m_d1 = '0; m_d2 = '0; m_sel = '0; m_res = '0; m_id = 1'b0;
      keep0 = 1'b0; keep1 = 1'b0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (!(keep0 && $urandom_range(0, 3) != 0)) begin
            REQ0_VALID = keep0 ? 1'b0 : 1'($urandom_range(0, 1));
            REQ0_OP = 3'($urandom); REQ0_A = 8'($urandom); REQ0_B = 8'($urandom);
         end
         if (!(keep1 && $urandom_range(0, 3) != 0)) begin
            REQ1_VALID = keep1 ? 1'b0 : 1'($urandom_range(0, 1));
            REQ1_OP = 3'($urandom); REQ1_A = 8'($urandom); REQ1_B = 8'($urandom);
         end
         RSP_READY = ($urandom_range(0, 2) != 0);
         #1;
         g = (mode == 0) ? pick(REQ0_VALID, REQ1_VALID, last) : -1;
         chk("rand ready0", REQ0_READY, (g == 0));
         chk("rand ready1", REQ1_READY, (g == 1));
         chk("rand rsp_valid", RSP_VALID, (mode == 2));
         if (mode == 2) begin
            chk("rand rsp_result", RSP_RESULT, m_res);
            chk("rand rsp_id", RSP_ID, m_id);
         end
         chk("rand alu regs", {ALU_SELECT, ALU_DATA1, ALU_DATA2}, {m_sel, m_d1, m_d2});
         keep0 = REQ0_VALID && (g != 0);
         keep1 = REQ1_VALID && (g != 1);
         if (g >= 0) begin
            m_sel = (g == 1) ? REQ1_OP : REQ0_OP;
            m_d1  = (g == 1) ? REQ1_A  : REQ0_A;
            m_d2  = (g == 1) ? REQ1_B  : REQ0_B;
            m_res = alu_f(m_sel, m_d1, m_d2);
            m_id  = (g == 1);
            last  = g;
            age   = 0;
            mode  = 1;
         end else if (mode == 1) begin
            age++;
            if (age == W) mode = 2;
         end else if (mode == 2 && RSP_READY) begin
            mode = 0;
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
